ex_operand_stage: RTL

Decode-to-execute pipeline register and operand-preparation stage of the RV32I core. Captures one decoded instruction per cycle, detects load-use and RAW hazards, resolves operand forwarding from the MEM and WB stages, and drives the ALU operand and control inputs directly. A load-use bubble or downstream stall back-pressures decode through a single ready signal.

---
 rtl/ex_operand_stage_pkg.sv | 70 +++++++
 rtl/ex_operand_stage_fwd_mux.sv | 42 ++++
 rtl/ex_operand_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_pkg
// Shared types and constants for the decode-to-execute operand stage.
//   XLEN / RA_W / ALU_W : datapath, register-address and ALU-control widths
//   alu_ctrl_e          : ALU control codes carried through the stage
//   op1_sel_e/op2_sel_e : operand select encodings
//   stage_t             : everything the stage holds for one instruction
//   reg_hit()           : "producer writes this source register" test
// Build option: define FORWARDING_EN to enable MEM/WB operand forwarding;
// without it, RAW dependences on in-flight producers stall the stage.
// ---------------------------------------------------------------------------
package ex_operand_stage_pkg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int ALU_W = 4;

`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_e;

    typedef enum logic {
        OP1_RS1 = 1'b0,
        OP1_PC  = 1'b1
    } op1_sel_e;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [RA_W-1:0]  rd;
        op1_sel_e         op1_sel;
        op2_sel_e         op2_sel;
        logic [ALU_W-1:0] alu_ctrl;
        logic             rd_we;
        logic             is_load;
    } stage_t;

    // x0 is never a real destination, so it never matches a source.
    function automatic logic reg_hit(input logic [RA_W-1:0] src,
                                     input logic            we,
                                     input logic [RA_W-1:0] dst);
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_fwd_mux
// Per-operand priority select: MEM result, else WB result, else held data.
// The hit flags are always produced; the stage uses them for RAW stalls and
// write-capture even when forwarding is compiled out (FORWARDING_EN).
//   src_addr / held_data          : held source register index and its data
//   mem_we/mem_rd_addr/mem_result : MEM-stage producer
//   wb_we/wb_rd_addr/wb_result    : WB-stage producer
//   data                          : operand value after forwarding
//   mem_hit / wb_hit              : producer writes src_addr
// ---------------------------------------------------------------------------
module ex_operand_stage_fwd_mux
    import ex_operand_stage_pkg::*;
(
    input  logic [RA_W-1:0] src_addr,
    input  logic [XLEN-1:0] held_data,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] data,
    output logic            mem_hit,
    output logic            wb_hit
);

    always_comb begin
        mem_hit = reg_hit(src_addr, mem_we, mem_rd_addr);
        wb_hit  = reg_hit(src_addr, wb_we, wb_rd_addr);
        data    = held_data;
        if (FWD_EN) begin
            // MEM holds the younger producer, so it wins over WB.
            if (mem_hit) begin
                data = mem_result;
            end else if (wb_hit) begin
                data = wb_result;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// Decode-to-execute pipeline register with hazard detection and operand
// preparation for the RV32I ALU.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready       : decode handshake (transfer when both high)
//   i_pc .. i_is_load       : decoded instruction fields and RF read data
//   i_ex_stall, i_flush     : downstream stall, redirect kill
//   i_mem_*, i_wb_*         : MEM / WB producers for forwarding
//   o_valid                 : held instruction issuable this cycle
//   o_op1, o_op2, o_rs2_val : ALU operands and store data
//   o_AluCtrl, o_pc, o_rd_addr, o_rd_we, o_is_load : pass-through fields
// Build option FORWARDING_EN: forward from MEM/WB; when undefined the stage
// stalls (o_valid low, contents held) on any RAW match with MEM/WB.
// Handshake: a decode transfer happens on a rising edge where i_valid and
// o_ready are both high; o_ready never depends on i_flush.
// ---------------------------------------------------------------------------
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [RA_W-1:0]  i_rs1_addr,
    input  logic [RA_W-1:0]  i_rs2_addr,
    input  logic [RA_W-1:0]  i_rd_addr,
    input  logic             i_op1_sel,
    input  logic             i_op2_sel,
    input  logic [ALU_W-1:0] i_AluCtrl,
    input  logic             i_rd_we,
    input  logic             i_is_load,
    input  logic             i_ex_stall,
    input  logic             i_flush,
    input  logic [RA_W-1:0]  i_mem_rd_addr,
    input  logic             i_mem_we,
    input  logic [XLEN-1:0]  i_mem_result,
    input  logic [RA_W-1:0]  i_wb_rd_addr,
    input  logic             i_wb_we,
    input  logic [XLEN-1:0]  i_wb_result,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_op1,
    output logic [XLEN-1:0]  o_op2,
    output logic [XLEN-1:0]  o_rs2_val,
    output logic [ALU_W-1:0] o_AluCtrl,
    output logic [XLEN-1:0]  o_pc,
    output logic [RA_W-1:0]  o_rd_addr,
    output logic             o_rd_we,
    output logic             o_is_load
);

    stage_t          st;
    stage_t          cap;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            mem_hit1;
    logic            wb_hit1;
    logic            mem_hit2;
    logic            wb_hit2;
    logic            load_use;
    logic            raw_stall;
    logic            hold;
    logic            take;

    ex_operand_stage_fwd_mux u_fwd_rs1 (
        .src_addr    (st.rs1),
        .held_data   (st.rs1_data),
        .mem_we      (i_mem_we),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_result  (i_mem_result),
        .wb_we       (i_wb_we),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_result   (i_wb_result),
        .data        (fwd_rs1),
        .mem_hit     (mem_hit1),
        .wb_hit      (wb_hit1)
    );

    ex_operand_stage_fwd_mux u_fwd_rs2 (
        .src_addr    (st.rs2),
        .held_data   (st.rs2_data),
        .mem_we      (i_mem_we),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_result  (i_mem_result),
        .wb_we       (i_wb_we),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_result   (i_wb_result),
        .data        (fwd_rs2),
        .mem_hit     (mem_hit2),
        .wb_hit      (wb_hit2)
    );

    // Both sources are compared regardless of use: spurious bubbles are
    // cheaper than decoding which operands the instruction really reads.
    assign load_use = st.valid && st.is_load && st.rd_we && (st.rd != '0) &&
                      i_valid &&
                      ((i_rs1_addr == st.rd) || (i_rs2_addr == st.rd));

    // Only meaningful without forwarding; FWD_EN folds it to zero.
    assign raw_stall = !FWD_EN && st.valid &&
                       (mem_hit1 || wb_hit1 || mem_hit2 || wb_hit2);

    assign hold    = i_ex_stall || raw_stall;
    assign o_ready = !i_ex_stall && !load_use && !raw_stall;
    assign take    = i_valid && o_ready;

    always_comb begin
        cap          = '0;
        cap.valid    = i_valid;
        cap.pc       = i_pc;
        cap.imm      = i_imm;
        cap.rs1_data = i_rs1_data;
        cap.rs2_data = i_rs2_data;
        cap.rs1      = i_rs1_addr;
        cap.rs2      = i_rs2_addr;
        cap.rd       = i_rd_addr;
        cap.op1_sel  = op1_sel_e'(i_op1_sel);
        cap.op2_sel  = op2_sel_e'(i_op2_sel);
        cap.alu_ctrl = i_AluCtrl;
        cap.rd_we    = i_rd_we;
        cap.is_load  = i_is_load;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st <= '0;
        end else if (i_flush) begin
            // Kill the held instruction but still accept the redirect target.
            if (take) begin
                st <= cap;
            end else begin
                st.valid <= 1'b0;
            end
        end else if (hold) begin
            // Grab retiring WB values so a long hold never loses them.
            if (wb_hit1) begin
                st.rs1_data <= i_wb_result;
            end
            if (wb_hit2) begin
                st.rs2_data <= i_wb_result;
            end
        end else if (load_use) begin
            st.valid <= 1'b0;
        end else begin
            st <= cap;
        end
    end

    assign o_valid   = st.valid && !raw_stall;
    assign o_op1     = (st.op1_sel == OP1_PC)  ? st.pc  : fwd_rs1;
    assign o_op2     = (st.op2_sel == OP2_IMM) ? st.imm : fwd_rs2;
    assign o_rs2_val = fwd_rs2;
    assign o_AluCtrl = st.alu_ctrl;
    assign o_pc      = st.pc;
    assign o_rd_addr = st.rd;
    assign o_rd_we   = st.rd_we;
    assign o_is_load = st.is_load;

endmodule
